// File: rtl/arm_reg_file.sv
// rtl/arm_reg_file.sv - ARM-style register file with integrated PC, link update and branch flush pulse
// Optional build macro: REGFILE_BYPASS_EN (same-cycle write-through on the read ports).
module arm_reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int PC_INDEX   = 15,
  parameter int LR_INDEX   = 14,
  parameter int PC_STEP    = 4,
  parameter int PC_RESET   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] writeDestination,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  linkBit,
  input  logic                  pcStall,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic [DATA_WIDTH-1:0] pcOut,
  output logic                  writeToPC
);

  localparam int                  NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_IDX  = ADDR_WIDTH'(PC_INDEX);
  localparam logic [ADDR_WIDTH-1:0] LR_IDX  = ADDR_WIDTH'(LR_INDEX);
  localparam logic [DATA_WIDTH-1:0] STEP1   = DATA_WIDTH'(PC_STEP);
  localparam logic [DATA_WIDTH-1:0] STEP2   = DATA_WIDTH'(2 * PC_STEP);
  localparam logic [DATA_WIDTH-1:0] PC_INIT = DATA_WIDTH'(PC_RESET);

  // The entry at PC_IDX is never written; the PC lives in r_pc instead.
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_pc;
  logic                  r_write_to_pc;

  logic                  w_branch;
  logic                  w_gen_write;
  logic                  w_link;
  logic [DATA_WIDTH-1:0] w_pc_plus_step;
  logic [DATA_WIDTH-1:0] w_pc_plus_two;
  logic [DATA_WIDTH-1:0] w_pc_next;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  assign w_branch       = writeEnable && (writeDestination == PC_IDX);
  assign w_gen_write    = writeEnable && (writeDestination != PC_IDX);
  assign w_link         = writeEnable && linkBit;
  // Sums wrap modulo 2**DATA_WIDTH; the carry is simply dropped.
  assign w_pc_plus_step = r_pc + STEP1;
  assign w_pc_plus_two  = r_pc + STEP2;

  // PC next-state: a branch beats a stall, a stall beats the normal step.
  always_comb begin
    w_pc_next = w_pc_plus_step;
    if (w_branch) begin
      w_pc_next = writeData;
    end else if (pcStall) begin
      w_pc_next = r_pc;
    end
  end

  // PC register and the one-cycle flush pulse that follows any branch edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= PC_INIT;
      r_write_to_pc <= 1'b0;
    end else begin
      r_pc          <= w_pc_next;
      r_write_to_pc <= w_branch;
    end
  end

  // General registers; the link write comes last so it wins over a same-index write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_gen_write) begin
        r_regs[writeDestination] <= writeData;
      end
      if (w_link) begin
        r_regs[LR_IDX] <= w_pc_plus_step;
      end
    end
  end

  // Read port 1: PC reads carry the two-step pipeline offset and are never bypassed.
  always_comb begin
    w_rd1 = (readReg1 == PC_IDX) ? w_pc_plus_two : r_regs[readReg1];
`ifdef REGFILE_BYPASS_EN
    if (readReg1 != PC_IDX) begin
      if (w_link && (readReg1 == LR_IDX)) begin
        w_rd1 = w_pc_plus_step;
      end else if (writeEnable && (readReg1 == writeDestination)) begin
        w_rd1 = writeData;
      end
    end
`endif
  end

  // Read port 2: identical to port 1, fully independent.
  always_comb begin
    w_rd2 = (readReg2 == PC_IDX) ? w_pc_plus_two : r_regs[readReg2];
`ifdef REGFILE_BYPASS_EN
    if (readReg2 != PC_IDX) begin
      if (w_link && (readReg2 == LR_IDX)) begin
        w_rd2 = w_pc_plus_step;
      end else if (writeEnable && (readReg2 == writeDestination)) begin
        w_rd2 = writeData;
      end
    end
`endif
  end

  assign readData1 = w_rd1;
  assign readData2 = w_rd2;
  assign pcOut     = r_pc;
  assign writeToPC = r_write_to_pc;

endmodule

// File: tb/tb_arm_reg_file.sv
// tb/tb_arm_reg_file.sv - scoreboard bench for arm_reg_file (default parameters)
`timescale 1ns/100ps
module tb_arm_reg_file;

  logic        clk;
  logic        reset;
  logic        writeEnable;
  logic [3:0]  writeDestination;
  logic [31:0] writeData;
  logic        linkBit;
  logic        pcStall;
  logic [3:0]  readReg1;
  logic [3:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] pcOut;
  logic        writeToPC;

  arm_reg_file dut (
    .clk              (clk),
    .reset            (reset),
    .writeEnable      (writeEnable),
    .writeDestination (writeDestination),
    .writeData        (writeData),
    .linkBit          (linkBit),
    .pcStall          (pcStall),
    .readReg1         (readReg1),
    .readReg2         (readReg2),
    .readData1        (readData1),
    .readData2        (readData2),
    .pcOut            (pcOut),
    .writeToPC        (writeToPC)
  );

  // 20 ns clock, rising edges at 10, 30, 50 ...
  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [3:0]  idx;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  localparam int SEL_RD1 = 0;
  localparam int SEL_RD2 = 1;
  localparam int SEL_PC  = 2;
  localparam int SEL_WPC = 3;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [3:0] idx, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.idx = idx;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Pop every pending expectation and compare it against the live outputs.
  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        SEL_RD1: begin readReg1 = e.idx; #0.2; check_eq(e.tag, readData1, e.exp); end
        SEL_RD2: begin readReg2 = e.idx; #0.2; check_eq(e.tag, readData2, e.exp); end
        SEL_PC:  begin #0.2; check_eq(e.tag, pcOut, e.exp); end
        default: begin #0.2; check_eq(e.tag, {31'd0, writeToPC}, e.exp); end
      endcase
    end
  endtask

  // Apply n rising edges; write strobes are single-edge, then settle at the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      writeEnable = 1'b0;
      linkBit     = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drive_write(input logic [3:0] dest, input logic [31:0] data, input logic lnk);
    writeEnable      = 1'b1;
    writeDestination = dest;
    writeData        = data;
    linkBit          = lnk;
  endtask

  initial begin
    reset = 1'b0;
    pcStall = 1'b0;
    readReg1 = 4'd0;
    readReg2 = 4'd0;
    drive_write(4'd3, 32'h0000_1234, 1'b0);

    // Reset state, with a write pending
    #3;
    push_exp("rst_pc",      SEL_PC,  4'd0,  32'h0);
    push_exp("rst_r15",     SEL_RD1, 4'd15, 32'h8);
    push_exp("rst_r0",      SEL_RD2, 4'd0,  32'h0);
    push_exp("rst_wpc",     SEL_WPC, 4'd0,  32'h0);
    drain();
    step(1);
    push_exp("rst_discard", SEL_RD1, 4'd3,  32'h0);
    push_exp("rst_pc_hold", SEL_PC,  4'd0,  32'h0);
    drain();

    // PC stepping and stall
    reset = 1'b1;
    step(3);
    push_exp("pc_step3",    SEL_PC,  4'd0,  32'd12);
    push_exp("pc_read_off", SEL_RD2, 4'd15, 32'd20);
    drain();
    pcStall = 1'b1;
    step(2);
    push_exp("pc_stall",    SEL_PC,  4'd0,  32'd12);
    drain();
    pcStall = 1'b0;

    // Write / read
    drive_write(4'd8, 32'hAAAA_AAAA, 1'b0);
    step(1);
    drive_write(4'd0, 32'hCCCC_CCCC, 1'b0);
    step(1);
    push_exp("wr_r8",       SEL_RD1, 4'd8,  32'hAAAA_AAAA);
    push_exp("wr_r0",       SEL_RD2, 4'd0,  32'hCCCC_CCCC);
    push_exp("wr_r1_zero",  SEL_RD1, 4'd1,  32'h0);
    push_exp("wr_r13_zero", SEL_RD2, 4'd13, 32'h0);
    push_exp("wr_r14_zero", SEL_RD1, 4'd14, 32'h0);
    push_exp("wr_pc",       SEL_PC,  4'd0,  32'd20);
    drain();

    // Asynchronous reset mid-cycle while a write is requested
    drive_write(4'd8, 32'h5555_5555, 1'b0);
    reset = 1'b0;
    #1;
    push_exp("arst_pc",     SEL_PC,  4'd0,  32'h0);
    push_exp("arst_r0",     SEL_RD2, 4'd0,  32'h0);
    push_exp("arst_r15",    SEL_RD1, 4'd15, 32'h8);
    drain();
    step(1);
    push_exp("arst_r8",     SEL_RD1, 4'd8,  32'h0);
    drain();
    reset = 1'b1;

    // Branch, then branch-with-link while stalled (back-to-back branches)
    drive_write(4'd15, 32'h20, 1'b0);
    step(1);
    push_exp("br_pc",       SEL_PC,  4'd0,  32'h20);
    push_exp("br_wpc",      SEL_WPC, 4'd0,  32'h1);
    drain();
    pcStall = 1'b1;
    drive_write(4'd15, 32'h100, 1'b1);
    step(1);
    pcStall = 1'b0;
    push_exp("bl_pc",       SEL_PC,  4'd0,  32'h100);
    push_exp("bl_lr",       SEL_RD1, 4'd14, 32'h24);
    push_exp("bl_wpc",      SEL_WPC, 4'd0,  32'h1);
    drain();
    step(1);
    push_exp("bl_pc_next",  SEL_PC,  4'd0,  32'h104);
    push_exp("bl_wpc_low",  SEL_WPC, 4'd0,  32'h0);
    drain();

    // Link conflict: link value wins over write-back to R14
    drive_write(4'd15, 32'h40, 1'b0);
    step(1);
    drive_write(4'd14, 32'h0000_DEAD, 1'b1);
    step(1);
    push_exp("lc_lr",       SEL_RD2, 4'd14, 32'h44);
    push_exp("lc_pc",       SEL_PC,  4'd0,  32'h44);
    push_exp("lc_wpc",      SEL_WPC, 4'd0,  32'h0);
    drain();

    // PC wrap
    drive_write(4'd15, 32'hFFFF_FFFC, 1'b0);
    step(1);
    push_exp("wrap_pc_top", SEL_PC,  4'd0,  32'hFFFF_FFFC);
    push_exp("wrap_rd_off", SEL_RD1, 4'd15, 32'h4);
    drain();
    step(1);
    push_exp("wrap_pc_0",   SEL_PC,  4'd0,  32'h0);
    drain();

    // Same-cycle reads during a write (bypass build vs registered build)
    drive_write(4'd3, 32'h11, 1'b0);
    step(1);
    drive_write(4'd3, 32'h55, 1'b1);
`ifdef REGFILE_BYPASS_EN
    push_exp("byp_r3",      SEL_RD1, 4'd3,  32'h55);
    push_exp("byp_lr",      SEL_RD2, 4'd14, 32'h8);
`else
    push_exp("byp_r3",      SEL_RD1, 4'd3,  32'h11);
    push_exp("byp_lr",      SEL_RD2, 4'd14, 32'h44);
`endif
    push_exp("byp_pc_read", SEL_RD1, 4'd15, 32'hC);
    drain();
    step(1);
    push_exp("post_r3",     SEL_RD1, 4'd3,  32'h55);
    push_exp("post_lr",     SEL_RD2, 4'd14, 32'h8);
    push_exp("post_r8",     SEL_RD1, 4'd8,  32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
